// File: rtl/key_expansion_sequencer_pkg.sv
// Shared constants for the AES-128 key expansion sequencer.
// FSM encoding, schedule dimensions and the xtime helper.
package key_expansion_sequencer_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam int NUM_ROUNDS = 10;
    localparam int KEY_BYTES  = 16;
    localparam int RK_DEPTH   = 176;

    localparam logic [7:0] XTIME_POLY = 8'h1B;

    typedef logic [7:0] kbyte_t;

    function automatic kbyte_t xtime(input kbyte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/key_round_store.sv
// 176x8 round-key store: one 16-byte row write per cycle and a
// registered single-byte read that sees the pre-write contents.
module key_round_store
    import key_expansion_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [3:0] wr_row,
    input  kbyte_t     wr_data [KEY_BYTES],
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data
);

    kbyte_t     mem [RK_DEPTH];
    logic [7:0] wr_base;

    assign wr_base = {wr_row, 4'b0000};

    always_ff @(posedge clk) begin
        if (we && (wr_row <= 4'(NUM_ROUNDS))) begin
            for (int i = 0; i < KEY_BYTES; i++) begin
                mem[wr_base + 8'(i)] <= wr_data[i];
            end
        end
    end

    // Addresses past the last round key read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else if (rd_addr < 8'(RK_DEPTH)) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= 8'h00;
        end
    end

endmodule

// File: rtl/key_expansion_sequencer.sv
// Sequences an external key-schedule stage through the ten AES-128
// rounds and records every round key in the round store.
module key_expansion_sequencer
    import key_expansion_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LAT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] key0,
    input  logic [DATA_W-1:0] key1,
    input  logic [DATA_W-1:0] key2,
    input  logic [DATA_W-1:0] key3,
    input  logic [DATA_W-1:0] key4,
    input  logic [DATA_W-1:0] key5,
    input  logic [DATA_W-1:0] key6,
    input  logic [DATA_W-1:0] key7,
    input  logic [DATA_W-1:0] key8,
    input  logic [DATA_W-1:0] key9,
    input  logic [DATA_W-1:0] key10,
    input  logic [DATA_W-1:0] key11,
    input  logic [DATA_W-1:0] key12,
    input  logic [DATA_W-1:0] key13,
    input  logic [DATA_W-1:0] key14,
    input  logic [DATA_W-1:0] key15,
    input  logic [LAT_W-1:0]  sched_latency,
    output logic [DATA_W-1:0] x0,
    output logic [DATA_W-1:0] x1,
    output logic [DATA_W-1:0] x2,
    output logic [DATA_W-1:0] x3,
    output logic [DATA_W-1:0] x4,
    output logic [DATA_W-1:0] x5,
    output logic [DATA_W-1:0] x6,
    output logic [DATA_W-1:0] x7,
    output logic [DATA_W-1:0] x8,
    output logic [DATA_W-1:0] x9,
    output logic [DATA_W-1:0] x10,
    output logic [DATA_W-1:0] x11,
    output logic [DATA_W-1:0] x12,
    output logic [DATA_W-1:0] x13,
    output logic [DATA_W-1:0] x14,
    output logic [DATA_W-1:0] x15,
    output logic [DATA_W-1:0] rcon,
    output logic              run,
    input  logic [DATA_W-1:0] y0,
    input  logic [DATA_W-1:0] y1,
    input  logic [DATA_W-1:0] y2,
    input  logic [DATA_W-1:0] y3,
    input  logic [DATA_W-1:0] y4,
    input  logic [DATA_W-1:0] y5,
    input  logic [DATA_W-1:0] y6,
    input  logic [DATA_W-1:0] y7,
    input  logic [DATA_W-1:0] y8,
    input  logic [DATA_W-1:0] y9,
    input  logic [DATA_W-1:0] y10,
    input  logic [DATA_W-1:0] y11,
    input  logic [DATA_W-1:0] y12,
    input  logic [DATA_W-1:0] y13,
    input  logic [DATA_W-1:0] y14,
    input  logic [DATA_W-1:0] y15,
    input  logic [7:0]        rk_addr,
    output logic [7:0]        rk_rdata,
    output logic              busy,
    output logic              done
);

    logic [2:0]       fsm;
    logic [3:0]       round;
    kbyte_t           rcon_q;
    logic [LAT_W-1:0] cnt;
    kbyte_t           st    [KEY_BYTES];
    kbyte_t           key_b [KEY_BYTES];
    kbyte_t           y_b   [KEY_BYTES];

    logic             we;
    logic [3:0]       wr_row;
    kbyte_t           wr_data [KEY_BYTES];
    logic             unused_hi;

    assign key_b[0]  = key0[7:0];
    assign key_b[1]  = key1[7:0];
    assign key_b[2]  = key2[7:0];
    assign key_b[3]  = key3[7:0];
    assign key_b[4]  = key4[7:0];
    assign key_b[5]  = key5[7:0];
    assign key_b[6]  = key6[7:0];
    assign key_b[7]  = key7[7:0];
    assign key_b[8]  = key8[7:0];
    assign key_b[9]  = key9[7:0];
    assign key_b[10] = key10[7:0];
    assign key_b[11] = key11[7:0];
    assign key_b[12] = key12[7:0];
    assign key_b[13] = key13[7:0];
    assign key_b[14] = key14[7:0];
    assign key_b[15] = key15[7:0];

    assign y_b[0]  = y0[7:0];
    assign y_b[1]  = y1[7:0];
    assign y_b[2]  = y2[7:0];
    assign y_b[3]  = y3[7:0];
    assign y_b[4]  = y4[7:0];
    assign y_b[5]  = y5[7:0];
    assign y_b[6]  = y6[7:0];
    assign y_b[7]  = y7[7:0];
    assign y_b[8]  = y8[7:0];
    assign y_b[9]  = y9[7:0];
    assign y_b[10] = y10[7:0];
    assign y_b[11] = y11[7:0];
    assign y_b[12] = y12[7:0];
    assign y_b[13] = y13[7:0];
    assign y_b[14] = y14[7:0];
    assign y_b[15] = y15[7:0];

    // Only the low byte of each word carries key material.
    assign unused_hi = ^{key0[DATA_W-1:8],  key1[DATA_W-1:8],
                         key2[DATA_W-1:8],  key3[DATA_W-1:8],
                         key4[DATA_W-1:8],  key5[DATA_W-1:8],
                         key6[DATA_W-1:8],  key7[DATA_W-1:8],
                         key8[DATA_W-1:8],  key9[DATA_W-1:8],
                         key10[DATA_W-1:8], key11[DATA_W-1:8],
                         key12[DATA_W-1:8], key13[DATA_W-1:8],
                         key14[DATA_W-1:8], key15[DATA_W-1:8],
                         y0[DATA_W-1:8],    y1[DATA_W-1:8],
                         y2[DATA_W-1:8],    y3[DATA_W-1:8],
                         y4[DATA_W-1:8],    y5[DATA_W-1:8],
                         y6[DATA_W-1:8],    y7[DATA_W-1:8],
                         y8[DATA_W-1:8],    y9[DATA_W-1:8],
                         y10[DATA_W-1:8],   y11[DATA_W-1:8],
                         y12[DATA_W-1:8],   y13[DATA_W-1:8],
                         y14[DATA_W-1:8],   y15[DATA_W-1:8]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm    <= S_IDLE;
            round  <= 4'd0;
            rcon_q <= 8'h00;
            cnt    <= '0;
            for (int i = 0; i < KEY_BYTES; i++) st[i] <= 8'h00;
        end else begin
            unique case (fsm)
                S_IDLE: begin
                    if (start) begin
                        st     <= key_b;
                        round  <= 4'd1;
                        rcon_q <= 8'h01;
                        fsm    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // A latency of zero behaves like one.
                    cnt <= (sched_latency == '0) ? '0
                         : sched_latency - LAT_W'(1);
                    fsm <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == '0) fsm <= S_CAPTURE;
                    else           cnt <= cnt - LAT_W'(1);
                end
                S_CAPTURE: begin
                    st <= y_b;
                    if (round == 4'(NUM_ROUNDS)) begin
                        fsm <= S_DONE;
                    end else begin
                        round  <= round + 4'd1;
                        rcon_q <= xtime(rcon_q);
                        fsm    <= S_ISSUE;
                    end
                end
                S_DONE:  fsm <= S_IDLE;
                default: fsm <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        we      = 1'b0;
        wr_row  = 4'd0;
        wr_data = key_b;
        unique case (1'b1)
            (fsm == S_IDLE) && start: we = 1'b1;
            (fsm == S_CAPTURE): begin
                we      = 1'b1;
                wr_row  = round;
                wr_data = y_b;
            end
            default: ;
        endcase
    end

    key_round_store u_store (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .wr_row  (wr_row),
        .wr_data (wr_data),
        .rd_addr (rk_addr),
        .rd_data (rk_rdata)
    );

    assign run  = (fsm == S_ISSUE);
    assign done = (fsm == S_DONE);
    assign busy = (fsm == S_ISSUE) || (fsm == S_WAIT)
               || (fsm == S_CAPTURE);

    assign rcon = DATA_W'(rcon_q);
    assign x0   = DATA_W'(st[0]);
    assign x1   = DATA_W'(st[1]);
    assign x2   = DATA_W'(st[2]);
    assign x3   = DATA_W'(st[3]);
    assign x4   = DATA_W'(st[4]);
    assign x5   = DATA_W'(st[5]);
    assign x6   = DATA_W'(st[6]);
    assign x7   = DATA_W'(st[7]);
    assign x8   = DATA_W'(st[8]);
    assign x9   = DATA_W'(st[9]);
    assign x10  = DATA_W'(st[10]);
    assign x11  = DATA_W'(st[11]);
    assign x12  = DATA_W'(st[12]);
    assign x13  = DATA_W'(st[13]);
    assign x14  = DATA_W'(st[14]);
    assign x15  = DATA_W'(st[15]);

endmodule
